// File: rtl/nibble_ser_pkg.sv
// Shared constants for the nibble serializer: state encoding, frame length and counter width.
// NIBBLE_SERIALIZER_PARITY_EN adds a trailing even-parity cycle to every frame.
package nibble_ser_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int WIDTH_MAX = 16;

`ifdef NIBBLE_SERIALIZER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  function automatic int frame_len(input int w);
    return PAR_EN ? w + 1 : w;
  endfunction

  localparam int FRAME_LEN = frame_len(WIDTH_DEF);
  // Sized for the widest legal word so the counter never needs resizing per instance.
  localparam int CNT_W = $clog2(frame_len(WIDTH_MAX));

endpackage

// File: rtl/sn_shift_reg.sv
// Parallel-load, shift-left register; the top bit is the registered serial output.
module sn_shift_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             top_o
);

  logic [WIDTH-1:0] data_q;

  // Zero fill means the register is empty once a full frame has shifted out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q <= data_i;
    end else if (shift_i) begin
      data_q <= {data_q[WIDTH-2:0], 1'b0};
    end
  end

  assign top_o = data_q[WIDTH-1];

endmodule

// File: rtl/nibble_serializer.sv
// Serializes word pairs A/B MSB-first with frame strobes for a bit-serial comparator.
// NIBBLE_SERIALIZER_PARITY_EN appends an even-parity cycle flagged by sn_par.
module nibble_serializer
  import nibble_ser_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sn_valid,
  input  logic [WIDTH-1:0] sn_a_in,
  input  logic [WIDTH-1:0] sn_b_in,
  output logic             sn_ready,
  output logic             sn_a,
  output logic             sn_b,
  output logic             sn_active,
  output logic             sn_first,
  output logic             sn_last,
  output logic             sn_par
);

  localparam int FLEN = frame_len(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sn_first_q;
  logic             sn_last_q;
  logic             sn_active_q;
  logic             accept;
  logic             shift_en;
  logic [FLEN-1:0]  load_a;
  logic [FLEN-1:0]  load_b;

  // The parity bit rides in the shift register's LSB so it emerges after the data LSB.
`ifdef NIBBLE_SERIALIZER_PARITY_EN
  logic sn_par_q;
  assign load_a = {sn_a_in, ^sn_a_in};
  assign load_b = {sn_b_in, ^sn_b_in};
  assign sn_par = sn_par_q;
`else
  assign load_a = sn_a_in;
  assign load_b = sn_b_in;
  assign sn_par = 1'b0;
`endif

  // cnt_q is 0 both in IDLE and on the final cycle of a frame.
  assign sn_ready = (state_q == ST_IDLE) || (cnt_q == '0);
  assign accept   = sn_valid && sn_ready;
  assign shift_en = (state_q == ST_SHIFT) && !accept;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      sn_first_q  <= 1'b0;
      sn_last_q   <= 1'b0;
      sn_active_q <= 1'b0;
`ifdef NIBBLE_SERIALIZER_PARITY_EN
      sn_par_q    <= 1'b0;
`endif
    end else if (accept) begin
      state_q     <= ST_SHIFT;
      cnt_q       <= CNT_LOAD;
      sn_first_q  <= 1'b1;
      sn_last_q   <= 1'b0;
      sn_active_q <= 1'b1;
`ifdef NIBBLE_SERIALIZER_PARITY_EN
      sn_par_q    <= 1'b0;
`endif
    end else begin
      sn_first_q <= 1'b0;
      case (state_q)
        ST_SHIFT: begin
          if (cnt_q == '0) begin
            state_q     <= ST_IDLE;
            sn_last_q   <= 1'b0;
            sn_active_q <= 1'b0;
`ifdef NIBBLE_SERIALIZER_PARITY_EN
            sn_par_q    <= 1'b0;
`endif
          end else begin
            cnt_q     <= cnt_q - CNT_ONE;
            sn_last_q <= (cnt_q == CNT_ONE);
`ifdef NIBBLE_SERIALIZER_PARITY_EN
            sn_par_q  <= (cnt_q == CNT_ONE);
`endif
          end
        end
        default: begin
          sn_last_q   <= 1'b0;
          sn_active_q <= 1'b0;
`ifdef NIBBLE_SERIALIZER_PARITY_EN
          sn_par_q    <= 1'b0;
`endif
        end
      endcase
    end
  end

  assign sn_first  = sn_first_q;
  assign sn_last   = sn_last_q;
  assign sn_active = sn_active_q;

  sn_shift_reg #(.WIDTH(FLEN)) u_sr_a (
    .clk     (clk),
    .reset   (reset),
    .load_i  (accept),
    .shift_i (shift_en),
    .data_i  (load_a),
    .top_o   (sn_a)
  );

  sn_shift_reg #(.WIDTH(FLEN)) u_sr_b (
    .clk     (clk),
    .reset   (reset),
    .load_i  (accept),
    .shift_i (shift_en),
    .data_i  (load_b),
    .top_o   (sn_b)
  );

endmodule

// File: tb/tb_nibble_serializer.sv
// Randomized bench for nibble_serializer against a queue-based per-cycle output model.
// Honors NIBBLE_SERIALIZER_PARITY_EN to match the DUT build.
module tb_nibble_serializer;

  localparam int W = 4;
`ifdef NIBBLE_SERIALIZER_PARITY_EN
  localparam int FLEN = W + 1;
  localparam bit PAR  = 1'b1;
`else
  localparam int FLEN = W;
  localparam bit PAR  = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         sn_valid = 1'b0;
  logic [W-1:0] sn_a_in = '0;
  logic [W-1:0] sn_b_in = '0;
  logic         sn_ready, sn_a, sn_b, sn_active, sn_first, sn_last, sn_par;

  int checks = 0;
  int errors = 0;

  // Each entry is one expected output cycle: {a, b, first, last, par}.
  logic [4:0] exp_q[$];
  logic [7:0] hist_a = '0;
  logic [7:0] hist_b = '0;

  always #5 clk = ~clk;

  nibble_serializer #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .sn_valid  (sn_valid),
    .sn_a_in   (sn_a_in),
    .sn_b_in   (sn_b_in),
    .sn_ready  (sn_ready),
    .sn_a      (sn_a),
    .sn_b      (sn_b),
    .sn_active (sn_active),
    .sn_first  (sn_first),
    .sn_last   (sn_last),
    .sn_par    (sn_par)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [W-1:0] wa, input logic [W-1:0] wb);
    for (int k = 0; k < FLEN; k++) begin
      logic ba, bb;
      ba = (k < W) ? wa[W-1-k] : ^wa;
      bb = (k < W) ? wb[W-1-k] : ^wb;
      exp_q.push_back({ba, bb, k == 0, k == FLEN - 1, PAR && (k == W)});
    end
  endtask

  // Called just after a falling edge: compare this cycle, drive inputs, advance the model.
  task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [4:0] e;
    logic       rdy;
    e   = (exp_q.size() > 0) ? exp_q[0] : 5'b0;
    rdy = (exp_q.size() <= 1);
    check_val("sn_ready",  sn_ready,  rdy);
    check_val("sn_active", sn_active, exp_q.size() > 0);
    check_val("sn_a",      sn_a,      e[4]);
    check_val("sn_b",      sn_b,      e[3]);
    check_val("sn_first",  sn_first,  e[2]);
    check_val("sn_last",   sn_last,   e[1]);
    check_val("sn_par",    sn_par,    e[0]);
    hist_a = {hist_a[6:0], sn_a};
    hist_b = {hist_b[6:0], sn_b};
    sn_valid = v;
    sn_a_in  = a;
    sn_b_in  = b;
    @(posedge clk);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    if (v && rdy) begin
      push_frame(a, b);
      $display("tx accept A=%h B=%h at %0t", a, b, $time);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0);
  endtask

  initial begin
    logic [7:0] exp_a, exp_b;
    // Reset then idle
    repeat (3) @(negedge clk);
    reset = 1'b0;
    idle(2);

    // Single frame with hand-derived serial streams
    step(1'b1, 4'b1010, 4'b0110);
    idle(FLEN);
`ifdef NIBBLE_SERIALIZER_PARITY_EN
    exp_a = 8'b0001_0100;
    exp_b = 8'b0000_1100;
    check_val("single_a_stream", {3'b0, hist_a[4:0]}, exp_a);
    check_val("single_b_stream", {3'b0, hist_b[4:0]}, exp_b);
`else
    exp_a = 8'h0A;
    exp_b = 8'h06;
    check_val("single_a_stream", {4'b0, hist_a[3:0]}, exp_a);
    check_val("single_b_stream", {4'b0, hist_b[3:0]}, exp_b);
`endif
    idle(2);

    // Back-to-back: valid held high across two words
    step(1'b1, 4'hF, 4'h0);
    for (int i = 0; i < FLEN - 1; i++) step(1'b1, 4'h3, 4'hC);
    step(1'b1, 4'h3, 4'hC);
    idle(FLEN + 1);

    // Busy ignore: pulse valid with A=5 in cycle 2
    step(1'b1, 4'b1001, 4'b0011);
    step(1'b0, '0, '0);
    step(1'b1, 4'h5, 4'h5);
    idle(FLEN + 1);

    // Reset mid-frame: outputs must drop without waiting for a clock edge
    step(1'b1, 4'b1100, 4'b1111);
    step(1'b0, '0, '0);
    #1 reset = 1'b1;
    #1;
    check_val("rst_sn_a",      sn_a,      1'b0);
    check_val("rst_sn_b",      sn_b,      1'b0);
    check_val("rst_sn_active", sn_active, 1'b0);
    check_val("rst_sn_first",  sn_first,  1'b0);
    check_val("rst_sn_last",   sn_last,   1'b0);
    check_val("rst_sn_par",    sn_par,    1'b0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, 4'b0101, 4'b1000);
    idle(FLEN + 1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 6, W'($urandom), W'($urandom));
    end
    idle(FLEN + 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
